// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with registered one-hot grant and encoded winner index.
// Round-robin or fixed priority, with optional bounded grant hold.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter bit RR_MODE  = 1'b1,
  parameter bit HOLD_EN  = 1'b0,
  parameter int MAX_HOLD = 4,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [IDX_W-1:0]  ptr, ptr_nxt, start, win;
  logic [HCNT_W-1:0] hcnt, hcnt_nxt;
  logic [N-1:0]      gnt_nxt, win_oh;
  logic [IDX_W-1:0]  idx_nxt;
  logic              hold, found;

  // Two-pass search: indices at or above start first, then wrap to the bottom.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    start  = RR_MODE ? ptr : '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(start))) begin
        found     = 1'b1;
        win       = IDX_W'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        win       = IDX_W'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_nxt  = '0;
    idx_nxt  = '0;
    ptr_nxt  = ptr;
    hcnt_nxt = hcnt;
    hold     = HOLD_EN && (|(gnt & req)) && (int'(hcnt) < MAX_HOLD - 1);
    if (hold) begin
      gnt_nxt  = gnt;
      idx_nxt  = gnt_idx;
      hcnt_nxt = hcnt + HCNT_W'(1);
    end else if (found) begin
      gnt_nxt  = win_oh;
      idx_nxt  = win;
      hcnt_nxt = '0;
      if (RR_MODE)
        ptr_nxt = (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
      else
        ptr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      hcnt    <= '0;
    end else begin
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      ptr     <= ptr_nxt;
      hcnt    <= hcnt_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-requester arbiter with registered one-hot grants. Successor to the 2-requester arbiter.
- Adds round-robin or fixed-priority mode, and optional grant hold with a bounded hold length.
- Sits between N bus masters and one shared resource. Drives gnt plus an encoded winner index.
- Designed to satisfy the team's arbiter property set generalised to N: mutual exclusion, and a grant implies its request was high on the previous cycle.

Parameters:
- N, 4, number of requesters; N >= 2.
- RR_MODE, 1, 1 = round-robin priority, 0 = fixed priority (index 0 highest).
- HOLD_EN, 0, 1 = the current winner keeps its grant while its request stays high, up to MAX_HOLD cycles.
- MAX_HOLD, 4, maximum consecutive grant cycles per winner when HOLD_EN = 1; MAX_HOLD >= 1.
- IDX_W, max(1, $clog2(N)), width of gnt_idx (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- req  input  N  request vector; req[i] high = requester i wants the resource.
- gnt  output  N  registered grant vector; one-hot or all-zero.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_idx  output  IDX_W  index of the granted requester; 0 when gnt_valid = 0.

Behaviour:
- Reset:
  - reset == 0 at a posedge sets gnt = 0, gnt_valid = 0, gnt_idx = 0, priority pointer ptr = 0 and hold counter hcnt = 0.
  - The req value in that cycle is ignored.
  - Reset asserted mid-grant clears everything at that edge; no grant survives reset.
- Latency:
  - The grant for cycle t+1 is computed from req(t), ptr(t), gnt(t) and hcnt(t).
  - req to gnt is exactly 1 cycle.
- Invariants:
  - gnt is one-hot or zero.
  - gnt[i](t+1) implies req[i](t).
  - gnt_valid equals the OR of all gnt bits.
  - gnt_idx equals the encoded gnt.
- Hold decision, evaluated before arbitration:
  - Applies when HOLD_EN = 1, gnt[i] = 1, req[i] = 1 and hcnt < MAX_HOLD-1.
  - Then gnt stays on i, hcnt increments and ptr is unchanged.
- Arbitration, used whenever the hold decision does not apply:
  - RR_MODE = 1: the winner is the first set req bit searching ptr, ptr+1, ..., wrapping modulo N. On a grant, ptr <= (winner+1) mod N.
  - RR_MODE = 0: the winner is the lowest set req index; ptr stays 0.
  - Any newly issued grant (hold not applied) sets hcnt = 0.
  - req == 0 gives gnt = 0 next cycle; ptr and hcnt are unchanged.
- Hold expiry:
  - When hcnt reaches MAX_HOLD-1, the winner re-arbitrates.
  - In RR mode ptr already points past it, so other pending requesters win first.
  - If it is the sole requester, it is re-granted with hcnt = 0. No idle bubble is inserted.
- Request drop: if the holder drops req, gnt moves (or clears) at the next edge regardless of hcnt.
- Wrap-around: ptr = N-1 with winner N-1 wraps ptr to 0.
- Fairness:
  - RR_MODE = 1, HOLD_EN = 0: a continuously asserted request is granted within N cycles.
  - RR_MODE = 1, HOLD_EN = 1: within (N-1)*MAX_HOLD+1 cycles.
  - Fixed mode carries no fairness guarantee.
- HOLD_EN = 0 behaves as MAX_HOLD = 1.

Test Plan:
1. Reset: N=4, reset=0 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0 throughout. Release reset with req=1111 -> gnt=0001, gnt_idx=0 at the next edge.
2. RR rotation, HOLD_EN=0: req=1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
3. Latency and drop: req=0100 from cycle t -> gnt=0100, gnt_idx=2 at t+1. req=0000 at t+3 -> gnt=0, gnt_valid=0 at t+4.
4. Hold, HOLD_EN=1, MAX_HOLD=3: req=0011 continuous -> gnt 0001 x3, 0010 x3, 0001 x3.
   - With req=0001 alone -> 0001 continuously, with no gap at each hold-counter reset.
5. Fixed priority, RR_MODE=0: req=1010 -> gnt=0010 every cycle. req becomes 1000 -> gnt=1000 one cycle later.
6. Reset mid-operation: with ptr=3 and gnt=0100, drive reset=0 for 1 cycle -> gnt=0 at that edge. After release, req=1111 -> gnt=0001, confirming ptr was reset to 0.
   - All scenarios: assertions check one-hot-or-zero gnt, gnt[i] implies past req[i], and gnt_idx consistent with gnt.
